jtframe_objscan: RTL and testbench
==================================

# jtframe_objscan

Scans the object attribute RAM once per line and feeds 16x16 sprite draw requests, one at a time, to the object drawer (`jtframe_objdraw_gate` family) through its `draw`/`busy` handshake. It sits between the object RAM (or its shadow copy) and the drawer. It skips entries that are disabled or not on the line being rendered. The drawer's line buffer then displays that line one line later.

## Interface
Parameters:
- `CW`, 12: code width, ≤16
- `PW`, 8: pixel width; palette field is PW-4 bits
- `AW`, 7: entry index width; table holds 2^AW entries
- `MAXOBJ`, 32: maximum draws per line; later visible entries are dropped

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `hs`  in  1  horizontal sync; its rising edge starts a scan
- `vrender`  in  9  line being drawn, already flip-adjusted
- `ram_addr`  out  AW+2  {entry, word}
- `ram_data`  in  16  RAM read data, valid 1 clk after `ram_addr`
- `draw`  out  1  one-clock draw strobe to the drawer
- `busy`  in  1  drawer busy
- `code`  out  CW  sprite code
- `xpos`  out  9  sprite x position
- `ysub`  out  4  row within the sprite, flip not applied
- `hflip`, `vflip`  out  1 each
- `pal`  out  PW-4  palette
- `scan_busy`  out  1  high from scan start until the scan ends
- `overflow`  out  1  MAXOBJ reached on this line; cleared at the next scan start

## Operation
Entry words:
- w0: [15] enable, [8:0] y
- w1: [8:0] x
- w2: [CW-1:0] code
- w3: [0] hflip, [1] vflip, [PW-3:2] pal

Visibility rule:
- `ydiff = vrender - y`, computed mod 512.
- An entry is visible iff enable=1 and ydiff[8:4]==0.
- On a visible entry, `ysub = ydiff[3:0]`.
- The drawer applies vflip itself.

State machine:
- IDLE: on an `hs` rising edge (registered compare against the previous `hs`), clear idx, count and overflow. Set scan_busy. Go to YA.
- YA: ram_addr={idx,0}.
- YC: sample w0 and set ram_addr={idx,1}.
  - Not visible: idx++, go to YA.
  - Visible: latch ysub, go to XL.
- XL: latch xpos and set addr w2.
- CL: latch code and set addr w3.
- AL: latch hflip, vflip and pal. Go to DR.
- DR: wait until busy=0, then pulse draw for one clk. count++. Go to W1.
- W1: one clk with draw=0, to cover the drawer's busy rise latency.
- WB: wait for busy=0. Then idx++ and go to YA.
- End of scan: leave for IDLE and clear scan_busy when either:
  - idx wraps past 2^AW-1, or
  - count reaches MAXOBJ. In this case, if any entry remains, set overflow.

Output stability:
- code, xpos, ysub, hflip, vflip and pal stay constant from the draw strobe until WB exits.
- The drawer is used with LATCH=0 and relies on this.

## Timing
- Reset values: draw=0, scan_busy=0, overflow=0, ram_addr=0, all latched outputs 0, state IDLE.
- Start latency: scan_busy rises 1 clk after the `hs` edge is detected. YA occurs the same cycle.
- Invisible entry: exactly 2 clks (YA, YC).
- Visible entry with an idle drawer: draw is asserted 5 clks after YA.
- Visible entry total cost: 5 + 1 + drawer busy time.
- `hs` edge mid-scan:
  - In YA through AL: restart immediately at idx 0 and clear count and overflow.
  - In DR, W1 or WB: set a restart flag. Finish the handshake (draw already issued, or suppress draw if still in DR). Restart when busy=0.
- `hs` held high: only one scan starts.
- `rst_n` low mid-draw forces draw=0 asynchronously. The drawer must share the same reset.

## Structure
- Shared package holds:
  - word offsets: W_Y=0, W_X=1, W_CODE=2, W_ATTR=3
  - field bit positions: ENABLE_BIT=15
  - state encoding
- Single module. No sub-module is warranted. Visibility is a 9-bit subtract plus a compare, kept inline.

## Test plan
- Single entry, vrender=40:
  - Entry 0 has enable, y=33, x=100, code=0x123, pal=5, and all others are disabled.
  - Required: exactly one draw with ysub=7, xpos=100, code=0x123.
  - scan_busy falls after 128 entries (~2*127+5+drawer clks).
- Wrap: y=0x1F8, vrender=3.
  - Required: visible, ysub=11.
  - y=0x1F8, vrender=8 → not visible.
- Drawer busy model with 20 clks busy, 3 visible entries:
  - Outputs do not change while busy=1.
  - The draw strobes are ≥22 clks apart.
- MAXOBJ=2 with 4 visible entries:
  - Required: 2 draws, overflow=1, and scan ends right after the second draw.
- `hs` pulse while in WB:
  - Current draw completes.
  - After busy falls, the scan restarts at entry 0.
  - overflow is cleared.
- Assert rst_n=0 during DR:
  - draw=0 immediately and state is IDLE.
  - No draw until the next `hs` edge.

Source files
------------

// File: rtl/jtframe_objscan_pkg.sv
// Shared constants for the object table scanner: entry word offsets,
// attribute bit positions and the scanner state encoding.
package jtframe_objscan_pkg;

  localparam logic [1:0] W_Y    = 2'd0;
  localparam logic [1:0] W_X    = 2'd1;
  localparam logic [1:0] W_CODE = 2'd2;
  localparam logic [1:0] W_ATTR = 2'd3;

  localparam int ENABLE_BIT = 15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_YA,
    ST_YC,
    ST_XL,
    ST_CL,
    ST_AL,
    ST_DR,
    ST_W1,
    ST_WB
  } state_t;

endpackage

// File: rtl/jtframe_objscan.sv
// Walks the object attribute table once per line and hands each visible
// 16x16 sprite to the object drawer through its draw/busy handshake.
module jtframe_objscan
  import jtframe_objscan_pkg::*;
#(
  parameter int CW     = 12,
  parameter int PW     = 8,
  parameter int AW     = 7,
  parameter int MAXOBJ = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs,
  input  logic [8:0]    vrender,
  output logic [AW+1:0] ram_addr,
  input  logic [15:0]   ram_data,
  output logic          draw,
  input  logic          busy,
  output logic [CW-1:0] code,
  output logic [8:0]    xpos,
  output logic [3:0]    ysub,
  output logic          hflip,
  output logic          vflip,
  output logic [PW-5:0] pal,
  output logic          scan_busy,
  output logic          overflow
);

  localparam int CNTW = $clog2(MAXOBJ + 1);

  state_t          st;
  logic            hs_l;
  logic [AW-1:0]   idx;
  logic [CNTW-1:0] cnt;
  logic            restart;
  logic            hs_edge;
  logic [8:0]      ydiff;
  logic            visible;
  logic            start_now;

  assign hs_edge = hs & ~hs_l;
  assign ydiff   = vrender - ram_data[8:0];
  assign visible = ram_data[ENABLE_BIT] && (ydiff[8:4] == 5'd0);

  // A new line request restarts at once unless a draw handshake is open;
  // then it is held in restart until the drawer goes idle.
  always_comb begin
    start_now = 1'b0;
    case (st)
      ST_IDLE, ST_YA, ST_YC, ST_XL, ST_CL, ST_AL: start_now = hs_edge;
      ST_DR:   start_now = (restart | hs_edge) & ~busy & ~draw;
      ST_WB:   start_now = (restart | hs_edge) & ~busy;
      default: start_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      hs_l      <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      restart   <= 1'b0;
      ram_addr  <= '0;
      draw      <= 1'b0;
      code      <= '0;
      xpos      <= '0;
      ysub      <= '0;
      hflip     <= 1'b0;
      vflip     <= 1'b0;
      pal       <= '0;
      scan_busy <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      hs_l <= hs;
      if (start_now) begin
        idx       <= '0;
        cnt       <= '0;
        overflow  <= 1'b0;
        restart   <= 1'b0;
        draw      <= 1'b0;
        scan_busy <= 1'b1;
        ram_addr  <= {{AW{1'b0}}, W_Y};
        st        <= ST_YA;
      end else begin
        if (hs_edge) restart <= 1'b1;
        case (st)
          ST_IDLE: ;
          // The address runs one word ahead because RAM data lags by a clock
          ST_YA: begin
            ram_addr <= {idx, W_X};
            st       <= ST_YC;
          end
          ST_YC: begin
            if (visible) begin
              ysub     <= ydiff[3:0];
              ram_addr <= {idx, W_CODE};
              st       <= ST_XL;
            end else if (&idx) begin
              scan_busy <= 1'b0;
              st        <= ST_IDLE;
            end else begin
              idx      <= idx + 1'b1;
              ram_addr <= {idx + 1'b1, W_Y};
              st       <= ST_YA;
            end
          end
          ST_XL: begin
            xpos     <= ram_data[8:0];
            ram_addr <= {idx, W_ATTR};
            st       <= ST_CL;
          end
          ST_CL: begin
            code <= ram_data[CW-1:0];
            st   <= ST_AL;
          end
          ST_AL: begin
            hflip <= ram_data[0];
            vflip <= ram_data[1];
            pal   <= ram_data[PW-3:2];
            if (!busy) begin
              draw <= 1'b1;
              cnt  <= cnt + 1'b1;
            end
            st <= ST_DR;
          end
          ST_DR: begin
            if (draw) begin
              draw <= 1'b0;
              st   <= ST_W1;
            end else if (!busy && !restart) begin
              draw <= 1'b1;
              cnt  <= cnt + 1'b1;
            end
          end
          ST_W1: st <= ST_WB;
          ST_WB: begin
            if (!busy) begin
              if (cnt == CNTW'(MAXOBJ)) begin
                overflow  <= ~&idx;
                scan_busy <= 1'b0;
                st        <= ST_IDLE;
              end else if (&idx) begin
                scan_busy <= 1'b0;
                st        <= ST_IDLE;
              end else begin
                idx      <= idx + 1'b1;
                ram_addr <= {idx + 1'b1, W_Y};
                st       <= ST_YA;
              end
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_objscan.sv
// Bench for jtframe_objscan: two scanners (MAXOBJ 32 and 2) share one object
// table; draws are compared with a line-visibility model of the table.
module tb_jtframe_objscan;

  localparam int CW = 12;
  localparam int PW = 8;
  localparam int AW = 7;
  localparam int NENT = 1 << AW;
  localparam int FW = CW + 9 + 4 + 2 + PW - 4;

  typedef struct {
    logic [FW-1:0] f;
    int            cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b0;
  logic [8:0] vrender = '0;

  logic [AW+1:0] a_ram_addr, b_ram_addr;
  logic [15:0]   a_ram_data, b_ram_data;
  logic          a_draw, b_draw, a_busy, b_busy;
  logic [CW-1:0] a_code, b_code;
  logic [8:0]    a_xpos, b_xpos;
  logic [3:0]    a_ysub, b_ysub;
  logic          a_hflip, b_hflip, a_vflip, b_vflip;
  logic [PW-5:0] a_pal, b_pal;
  logic          a_scan_busy, b_scan_busy, a_overflow, b_overflow;

  jtframe_objscan #(.CW(CW), .PW(PW), .AW(AW), .MAXOBJ(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vrender(vrender),
    .ram_addr(a_ram_addr), .ram_data(a_ram_data), .draw(a_draw), .busy(a_busy),
    .code(a_code), .xpos(a_xpos), .ysub(a_ysub), .hflip(a_hflip), .vflip(a_vflip),
    .pal(a_pal), .scan_busy(a_scan_busy), .overflow(a_overflow)
  );

  jtframe_objscan #(.CW(CW), .PW(PW), .AW(AW), .MAXOBJ(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vrender(vrender),
    .ram_addr(b_ram_addr), .ram_data(b_ram_data), .draw(b_draw), .busy(b_busy),
    .code(b_code), .xpos(b_xpos), .ysub(b_ysub), .hflip(b_hflip), .vflip(b_vflip),
    .pal(b_pal), .scan_busy(b_scan_busy), .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:4*NENT-1];
  always @(posedge clk) begin
    a_ram_data <= mem[a_ram_addr];
    b_ram_data <= mem[b_ram_addr];
  end

  // Drawer stand-in: busy for busy_len clocks after accepting a draw
  int busy_len = 20;
  int a_bcnt, b_bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_bcnt <= 0;
      b_bcnt <= 0;
    end else begin
      if (a_draw && a_bcnt == 0) a_bcnt <= busy_len;
      else if (a_bcnt != 0)      a_bcnt <= a_bcnt - 1;
      if (b_draw && b_bcnt == 0) b_bcnt <= busy_len;
      else if (b_bcnt != 0)      b_bcnt <= b_bcnt - 1;
    end
  end
  assign a_busy = (a_bcnt != 0);
  assign b_busy = (b_bcnt != 0);

  logic [FW-1:0] a_f, b_f;
  assign a_f = {a_code, a_xpos, a_ysub, a_hflip, a_vflip, a_pal};
  assign b_f = {b_code, b_xpos, b_ysub, b_hflip, b_vflip, b_pal};

  rec_t a_q[$], b_q[$];
  int a_stab = 0, b_stab = 0, a_dwb = 0, b_dwb = 0;
  always @(negedge clk) begin
    if (a_draw) begin
      if (a_busy) a_dwb++;
      a_q.push_back('{f: a_f, cyc: cyc});
    end else if (a_busy && a_q.size() != 0 && a_f !== a_q[$].f) a_stab++;
    if (b_draw) begin
      if (b_busy) b_dwb++;
      b_q.push_back('{f: b_f, cyc: cyc});
    end else if (b_busy && b_q.size() != 0 && b_f !== b_q[$].f) b_stab++;
  end

  // Object table as the bench sees it
  bit       ent_en   [NENT];
  int       ent_y    [NENT];
  int       ent_x    [NENT];
  int       ent_code [NENT];
  bit       ent_hf   [NENT];
  bit       ent_vf   [NENT];
  int       ent_pal  [NENT];

  logic [FW-1:0] ex_a[$], ex_b[$];
  bit ov_a, ov_b;
  int checks = 0, errors = 0;
  int sa, sb, t0, a_end, b_end, sta0, stb0, dwa0, dwb0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NENT; i++) begin
      ent_en[i]   = 1'b0;
      ent_y[i]    = $urandom_range(0, 511);
      ent_x[i]    = $urandom_range(0, 511);
      ent_code[i] = $urandom_range(0, (1 << CW) - 1);
      ent_hf[i]   = 1'($urandom_range(0, 1));
      ent_vf[i]   = 1'($urandom_range(0, 1));
      ent_pal[i]  = $urandom_range(0, (1 << (PW - 4)) - 1);
    end
  endtask

  task automatic set_entry(input int i, input int y, input int x, input int c, input int p);
    ent_en[i] = 1'b1; ent_y[i] = y; ent_x[i] = x; ent_code[i] = c; ent_pal[i] = p;
  endtask

  // Unused word bits carry junk so the scanner must mask its fields
  task automatic load_mem();
    logic [15:0] junk;
    for (int i = 0; i < NENT; i++) begin
      junk = 16'($urandom);
      mem[4*i+0] = {ent_en[i], junk[14:9], 9'(ent_y[i])};
      mem[4*i+1] = {junk[15:9], 9'(ent_x[i])};
      mem[4*i+2] = {junk[15:CW], CW'(ent_code[i])};
      mem[4*i+3] = {junk[15:PW-2], (PW-4)'(ent_pal[i]), ent_vf[i], ent_hf[i]};
    end
  endtask

  function automatic logic [FW-1:0] fields(input int i, input int dy);
    return {CW'(ent_code[i]), 9'(ent_x[i]), 4'(dy % 16), ent_hf[i], ent_vf[i], (PW-4)'(ent_pal[i])};
  endfunction

  // Reference: every enabled entry whose line offset is below 16, in table order
  task automatic expect_scan(input int maxobj, input bit to_b);
    int n, dy;
    bit ov;
    n = 0; ov = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      dy = (int'(vrender) - ent_y[i] + 512) % 512;
      if (ent_en[i] && dy < 16) begin
        if (to_b) ex_b.push_back(fields(i, dy)); else ex_a.push_back(fields(i, dy));
        n++;
        if (n == maxobj) begin
          ov = (i < NENT - 1);
          break;
        end
      end
    end
    if (to_b) ov_b = ov; else ov_a = ov;
  endtask

  task automatic start_scan(input bit hold);
    sa = a_q.size(); sb = b_q.size();
    sta0 = a_stab; stb0 = b_stab; dwa0 = a_dwb; dwb0 = b_dwb;
    a_end = -1; b_end = -1;
    @(negedge clk) hs = 1'b1;
    @(negedge clk);
    check("scan_busy_start", a_scan_busy, 1);
    t0 = cyc;
    if (!hold) hs = 1'b0;
  endtask

  task automatic finish_scan();
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      if (a_end < 0 && a_scan_busy === 1'b0) a_end = cyc;
      if (b_end < 0 && b_scan_busy === 1'b0) b_end = cyc;
      if (a_end >= 0 && b_end >= 0) break;
    end
    check("scan_end_in_time", (a_end >= 0 && b_end >= 0), 1);
    check("a_draw_count", a_q.size() - sa, ex_a.size());
    check("b_draw_count", b_q.size() - sb, ex_b.size());
    for (int i = 0; i < ex_a.size() && sa + i < a_q.size(); i++)
      check("a_draw_fields", a_q[sa+i].f, ex_a[i]);
    for (int i = 0; i < ex_b.size() && sb + i < b_q.size(); i++)
      check("b_draw_fields", b_q[sb+i].f, ex_b[i]);
    check("a_overflow", a_overflow, ov_a);
    check("b_overflow", b_overflow, ov_b);
    check("outputs_stable_while_busy", (a_stab - sta0) + (b_stab - stb0), 0);
    check("no_draw_while_busy", (a_dwb - dwa0) + (b_dwb - dwb0), 0);
  endtask

  task automatic plain_expect();
    ex_a.delete(); ex_b.delete();
    expect_scan(32, 1'b0);
    expect_scan(2, 1'b1);
  endtask

  initial begin
    int held, n0, found;

    // Reset state
    clear_table(); load_mem();
    repeat (3) @(negedge clk);
    check("reset_draw", a_draw, 0);
    check("reset_scan_busy", a_scan_busy, 0);
    check("reset_overflow", a_overflow, 0);
    check("reset_ram_addr", a_ram_addr, 0);
    check("reset_fields", a_f, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single entry on line 40, hs held high across the whole scan
    clear_table();
    set_entry(0, 33, 100, 'h123, 5);
    ent_hf[0] = 1'b0; ent_vf[0] = 1'b0;
    load_mem();
    vrender = 9'd40; busy_len = 20;
    plain_expect();
    start_scan(1'b1);
    finish_scan();
    if (a_q.size() > sa) check("draw_latency", a_q[sa].cyc - t0, 5);
    check("scan_length", (a_end - t0 >= 2*127 + 5 + 20) && (a_end - t0 <= 2*127 + 5 + 20 + 12), 1);
    held = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_scan_busy) held++;
    end
    check("hs_held_single_scan", held, 0);
    hs = 1'b0;

    // Line offset wraps modulo 512
    clear_table();
    set_entry(0, 'h1F8, 7, 'h0AB, 3);
    load_mem();
    vrender = 9'd3;
    plain_expect();
    start_scan(1'b0);
    finish_scan();
    if (a_q.size() > sa) check("wrap_ysub", a_q[sa].f[PW-4+2 +: 4], 11);
    vrender = 9'd8;
    plain_expect();
    start_scan(1'b0);
    finish_scan();

    // Slow drawer with three visible entries
    clear_table();
    vrender = 9'd200;
    set_entry(5, 195, 10, 'h005, 1);
    set_entry(40, 186, 20, 'h028, 2);
    set_entry(90, 200, 30, 'h05A, 3);
    load_mem();
    plain_expect();
    start_scan(1'b0);
    finish_scan();
    for (int i = 1; i < 3; i++)
      if (a_q.size() > sa + i) check("draw_spacing", (a_q[sa+i].cyc - a_q[sa+i-1].cyc) >= 22, 1);

    // More visible entries than MAXOBJ on the small scanner
    clear_table();
    vrender = 9'd64;
    for (int i = 2; i < 6; i++) set_entry(i, 60 - i, 16 * i, 'h300 + i, i);
    load_mem();
    plain_expect();
    start_scan(1'b0);
    finish_scan();
    if (b_q.size() > sb + 1) check("b_end_after_last_draw", (b_end - b_q[sb+1].cyc) <= busy_len + 3, 1);

    // Randomised tables and drawer speeds
    for (int k = 0; k < 4; k++) begin
      clear_table();
      vrender = 9'($urandom_range(0, 511));
      busy_len = $urandom_range(0, 8);
      for (int i = 0; i < NENT; i++) begin
        ent_y[i] = (int'(vrender) + 512 - $urandom_range(0, 24)) % 512;
        ent_en[i] = ($urandom_range(0, 7) == 0);
      end
      load_mem();
      plain_expect();
      start_scan(1'b0);
      finish_scan();
    end

    // hs arrives while waiting on the drawer: finish the draw, then restart
    busy_len = 20;
    clear_table();
    vrender = 9'd100;
    for (int i = 0; i < 4; i++) set_entry(i, 90 + i, 50 + i, 'h400 + i, i);
    load_mem();
    plain_expect();
    start_scan(1'b0);
    finish_scan();
    ex_a.delete(); ex_b.delete();
    ex_a.push_back(fields(0, 10));
    ex_b.push_back(fields(0, 10));
    expect_scan(32, 1'b0);
    expect_scan(2, 1'b1);
    start_scan(1'b0);
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_q.size() > sb) begin found = 1; break; end
    end
    check("first_draw_seen", found, 1);
    repeat (3) @(negedge clk);
    hs = 1'b1;
    @(negedge clk) hs = 1'b0;
    found = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (b_q.size() > sb + 1) begin found = 1; break; end
    end
    check("redraw_after_restart", found, 1);
    check("overflow_cleared_on_restart", b_overflow, 0);
    finish_scan();

    // Reset while draw is high
    clear_table();
    vrender = 9'd50;
    set_entry(0, 45, 77, 'h0EE, 6);
    load_mem();
    plain_expect();
    start_scan(1'b0);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (a_draw) begin found = 1; break; end
    end
    check("draw_before_reset", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_kills_draw", a_draw, 0);
    check("reset_kills_scan", a_scan_busy, 0);
    check("reset_addr_idle", a_ram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = a_q.size();
    repeat (40) @(negedge clk);
    check("no_draw_after_reset", a_q.size() - n0, 0);
    plain_expect();
    start_scan(1'b0);
    finish_scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
